// File: rtl/gray_ring_pkg.sv
// Shared codes for the Gray-ring monitor: ring state codes, move classes,
// FSM encoding and ring successor/predecessor helpers.
package gray_ring_pkg;

  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S10 = 2'b10;
  localparam logic [1:0] S11 = 2'b11;
  localparam logic [1:0] S01 = 2'b01;

  typedef enum logic [1:0] {HOLD, FWD, BACK, SKIP} move_t;

  typedef enum logic [1:0] {IDLE, TRACK, FAULT} fsm_t;

  // Forward ring order: 00 -> 10 -> 11 -> 01 -> 00
  function automatic logic [1:0] ring_next(input logic [1:0] s);
    case (s)
      S00:     ring_next = S10;
      S10:     ring_next = S11;
      S11:     ring_next = S01;
      default: ring_next = S00;
    endcase
  endfunction

  function automatic logic [1:0] ring_prev(input logic [1:0] s);
    case (s)
      S00:     ring_prev = S01;
      S10:     ring_prev = S00;
      S11:     ring_prev = S10;
      default: ring_prev = S11;
    endcase
  endfunction

endpackage

// File: rtl/ring_step_decode.sv
// Combinational classifier of one observed move prev -> st_in on the Gray ring.
module ring_step_decode
  import gray_ring_pkg::*;
(
  input  logic [1:0] prev,
  input  logic [1:0] st_in,
  output logic [1:0] move
);

  always_comb begin
    move = SKIP;
    if (st_in == prev)
      move = HOLD;
    else if (st_in == ring_next(prev))
      move = FWD;
    else if (st_in == ring_prev(prev))
      move = BACK;
  end

endmodule

// File: rtl/gray_ring_monitor.sv
// Gray-ring move checker: revolution count, dwell timer, stall and illegal-move flags.
// Build option GRAY_RING_BIDIR_EN makes backward moves legal and adds step_rev.
module gray_ring_monitor
  import gray_ring_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int DWELL_W   = 8,
  parameter int DWELL_MAX = 16
) (
  input  logic               clk,
  input  logic               res,
  input  logic [1:0]         st_in,
  input  logic               st_valid,
  output logic               step,
  output logic               illegal,
  output logic               locked,
  output logic               stall,
`ifdef GRAY_RING_BIDIR_EN
  output logic               step_rev,
`endif
  output logic [CNT_W-1:0]   rev_cnt,
  output logic [DWELL_W-1:0] dwell
);

  // state | meaning
  // IDLE  | no sample seen since reset, no reference state yet
  // TRACK | following the ring, every move so far legal
  // FAULT | last move was illegal, waiting for a legal advance

  localparam logic [DWELL_W-1:0] DMAX = DWELL_W'(DWELL_MAX);

  fsm_t               state;
  logic [1:0]         prev;
  logic [1:0]         mv_raw;
  move_t              mv;
  logic [DWELL_W-1:0] dwell_inc;

  ring_step_decode u_dec (
    .prev  (prev),
    .st_in (st_in),
    .move  (mv_raw)
  );

  assign mv        = move_t'(mv_raw);
  assign dwell_inc = (dwell == '1) ? dwell : dwell + 1'b1;

  always_ff @(posedge clk) begin
    if (res) begin
      state    <= IDLE;
      prev     <= S00;
      step     <= 1'b0;
      illegal  <= 1'b0;
      locked   <= 1'b0;
      stall    <= 1'b0;
      rev_cnt  <= '0;
      dwell    <= '0;
`ifdef GRAY_RING_BIDIR_EN
      step_rev <= 1'b0;
`endif
    end else begin
      step     <= 1'b0;
      illegal  <= 1'b0;
`ifdef GRAY_RING_BIDIR_EN
      step_rev <= 1'b0;
`endif
      if (st_valid) begin
        prev <= st_in;
        case (state)
          IDLE: begin
            dwell  <= '0;
            stall  <= 1'b0;
            locked <= 1'b1;
            state  <= TRACK;
          end
          TRACK: begin
            case (mv)
              HOLD: begin
                dwell <= dwell_inc;
                stall <= (dwell_inc >= DMAX);
              end
              FWD: begin
                step  <= 1'b1;
                dwell <= '0;
                stall <= 1'b0;
                if (prev == S01)
                  rev_cnt <= rev_cnt + 1'b1;
              end
`ifdef GRAY_RING_BIDIR_EN
              BACK: begin
                step_rev <= 1'b1;
                dwell    <= '0;
                stall    <= 1'b0;
                if (prev == S00)
                  rev_cnt <= rev_cnt - 1'b1;
              end
`endif
              default: begin
                illegal <= 1'b1;
                dwell   <= '0;
                stall   <= 1'b0;
                locked  <= 1'b0;
                state   <= FAULT;
              end
            endcase
          end
          FAULT: begin
            stall <= 1'b0;
            case (mv)
              HOLD: dwell <= dwell_inc;
              // Recovery advance never counts a revolution: history is untrusted.
              FWD: begin
                step   <= 1'b1;
                dwell  <= '0;
                locked <= 1'b1;
                state  <= TRACK;
              end
`ifdef GRAY_RING_BIDIR_EN
              BACK: begin
                step_rev <= 1'b1;
                dwell    <= '0;
                locked   <= 1'b1;
                state    <= TRACK;
              end
`endif
              default: begin
                illegal <= 1'b1;
                dwell   <= '0;
              end
            endcase
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
            stall  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gray_ring_monitor.sv
// Directed bench for gray_ring_monitor (CNT_W=2 to expose revolution wrap).
module tb_gray_ring_monitor;

  logic       clk = 1'b0;
  logic       res;
  logic [1:0] st_in;
  logic       st_valid;
  logic       step, illegal, locked, stall;
  logic [1:0] rev_cnt;
  logic [7:0] dwell;
`ifdef GRAY_RING_BIDIR_EN
  logic       step_rev;
`endif

  int n_vec = 0;
  int n_bad = 0;

  gray_ring_monitor #(.CNT_W(2), .DWELL_W(8), .DWELL_MAX(16)) dut (
    .clk      (clk),
    .res      (res),
    .st_in    (st_in),
    .st_valid (st_valid),
    .step     (step),
    .illegal  (illegal),
    .locked   (locked),
    .stall    (stall),
`ifdef GRAY_RING_BIDIR_EN
    .step_rev (step_rev),
`endif
    .rev_cnt  (rev_cnt),
    .dwell    (dwell)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       v;
    logic [1:0] s;
    logic       e_st;
    logic       e_il;
    logic       e_lk;
    logic       e_sl;
    logic [1:0] e_rv;
    logic [7:0] e_dw;
  } vec_t;

  vec_t tbl[23];

  task automatic apply(input logic r, input logic v, input logic [1:0] s);
    res = r; st_valid = v; st_in = s;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic e_st, input logic e_il,
                     input logic e_lk, input logic e_sl, input logic [1:0] e_rv,
                     input logic [7:0] e_dw, input logic e_sr);
    logic sr;
`ifdef GRAY_RING_BIDIR_EN
    sr = step_rev;
`else
    sr = e_sr;
`endif
    n_vec++;
    if ({step, illegal, locked, stall, rev_cnt, dwell, sr} !==
        {e_st, e_il, e_lk, e_sl, e_rv, e_dw, e_sr}) begin
      n_bad++;
      $display("FAIL %s: got step=%b ill=%b lock=%b stall=%b rev=%0d dwell=%0d srev=%b, expected step=%b ill=%b lock=%b stall=%b rev=%0d dwell=%0d srev=%b",
               nm, step, illegal, locked, stall, rev_cnt, dwell, sr,
               e_st, e_il, e_lk, e_sl, e_rv, e_dw, e_sr);
    end
  endtask

  initial begin
    //           r  v  s      st il lk sl rv dw
    tbl[0]  = '{1, 0, 2'b00, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 2'b00, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 2'b00, 0, 0, 1, 0, 0, 0};
    tbl[3]  = '{0, 1, 2'b10, 1, 0, 1, 0, 0, 0};
    tbl[4]  = '{0, 1, 2'b11, 1, 0, 1, 0, 0, 0};
    tbl[5]  = '{0, 1, 2'b01, 1, 0, 1, 0, 0, 0};
    tbl[6]  = '{0, 1, 2'b00, 1, 0, 1, 0, 1, 0};
    // same ring with gaps; invalid samples carry junk codes
    tbl[7]  = '{0, 0, 2'b11, 0, 0, 1, 0, 1, 0};
    tbl[8]  = '{0, 1, 2'b10, 1, 0, 1, 0, 1, 0};
    tbl[9]  = '{0, 0, 2'b01, 0, 0, 1, 0, 1, 0};
    tbl[10] = '{0, 1, 2'b11, 1, 0, 1, 0, 1, 0};
    tbl[11] = '{0, 0, 2'b00, 0, 0, 1, 0, 1, 0};
    tbl[12] = '{0, 1, 2'b01, 1, 0, 1, 0, 1, 0};
    tbl[13] = '{0, 0, 2'b10, 0, 0, 1, 0, 1, 0};
    tbl[14] = '{0, 1, 2'b00, 1, 0, 1, 0, 2, 0};
    // hold, skip into FAULT, recover, wrap
    tbl[15] = '{0, 1, 2'b00, 0, 0, 1, 0, 2, 1};
    tbl[16] = '{0, 1, 2'b11, 0, 1, 0, 0, 2, 0};
    tbl[17] = '{0, 1, 2'b01, 1, 0, 1, 0, 2, 0};
    tbl[18] = '{0, 1, 2'b01, 0, 0, 1, 0, 2, 1};
    tbl[19] = '{0, 1, 2'b00, 1, 0, 1, 0, 3, 0};
    // reset mid-ring, then restart from 01
    tbl[20] = '{1, 1, 2'b10, 0, 0, 0, 0, 0, 0};
    tbl[21] = '{0, 1, 2'b01, 0, 0, 1, 0, 0, 0};
    tbl[22] = '{0, 1, 2'b00, 1, 0, 1, 0, 1, 0};

    res = 1'b1; st_valid = 1'b0; st_in = 2'b00;
    for (int i = 0; i < 23; i++) begin
      apply(tbl[i].r, tbl[i].v, tbl[i].s);
      chk($sformatf("tbl%0d", i), tbl[i].e_st, tbl[i].e_il, tbl[i].e_lk,
          tbl[i].e_sl, tbl[i].e_rv, tbl[i].e_dw, 1'b0);
    end

    // three more revolutions: 1 -> 2 -> 3 -> 0
    for (int r = 0; r < 3; r++) begin
      logic [1:0] er;
      er = 2'(r + 2);
      apply(0, 1, 2'b10); chk($sformatf("rev%0d_10", r), 1, 0, 1, 0, 2'(r + 1), 0, 0);
      apply(0, 1, 2'b11); chk($sformatf("rev%0d_11", r), 1, 0, 1, 0, 2'(r + 1), 0, 0);
      apply(0, 1, 2'b01); chk($sformatf("rev%0d_01", r), 1, 0, 1, 0, 2'(r + 1), 0, 0);
      apply(0, 1, 2'b00); chk($sformatf("rev%0d_00", r), 1, 0, 1, 0, er, 0, 0);
    end

    // dwell and stall threshold
    apply(0, 1, 2'b10); chk("dw_enter", 1, 0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 19; i++) begin
      apply(0, 1, 2'b10);
      chk($sformatf("dw%0d", i), 0, 0, 1, (i >= 16), 0, 8'(i), 0);
    end
    apply(0, 1, 2'b11); chk("dw_clear", 1, 0, 1, 0, 0, 0, 0);

    // dwell saturation
    for (int i = 0; i < 260; i++) apply(0, 1, 2'b11);
    chk("dw_sat", 0, 0, 1, 1, 0, 8'd255, 0);
    apply(0, 1, 2'b01); chk("dw_sat_clr", 1, 0, 1, 0, 0, 0, 0);

    // FAULT: dwell counts, no stall, repeated illegal, recovery 01->00 not counted
    apply(0, 1, 2'b10); chk("flt_skip", 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) apply(0, 1, 2'b10);
    chk("flt_hold", 0, 0, 0, 0, 0, 8'd20, 0);
    apply(0, 1, 2'b01); chk("flt_skip2", 0, 1, 0, 0, 0, 0, 0);
    apply(0, 1, 2'b00); chk("flt_recover", 1, 0, 1, 0, 0, 0, 0);

    // backward moves from TRACK at 00 with rev_cnt=0
`ifdef GRAY_RING_BIDIR_EN
    apply(0, 1, 2'b01); chk("back_trk", 0, 0, 1, 0, 2'd3, 0, 1);
    apply(0, 1, 2'b10); chk("back_skip", 0, 1, 0, 0, 2'd3, 0, 0);
    apply(0, 1, 2'b00); chk("back_flt", 0, 0, 1, 0, 2'd3, 0, 1);
    apply(0, 1, 2'b01); chk("back_trk2", 0, 0, 1, 0, 2'd2, 0, 1);
`else
    apply(0, 1, 2'b01); chk("back_trk", 0, 1, 0, 0, 0, 0, 0);
    apply(0, 1, 2'b10); chk("back_skip", 0, 1, 0, 0, 0, 0, 0);
    apply(0, 1, 2'b00); chk("back_flt", 0, 1, 0, 0, 0, 0, 0);
    apply(0, 1, 2'b10); chk("back_recover", 1, 0, 1, 0, 0, 0, 0);
`endif

    apply(1, 1, 2'b11); chk("final_reset", 0, 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
